decode_stage: RTL and testbench

//  Instruction-decode pipeline stage, and the producer of the 4-bit alu op code and operands.
//  - Accepts a fetched RV32I instruction and its PC over a valid/ready handshake.
//  - Reads both register-file ports and builds immediates.
//  - Drives one registered decode bundle (alu_a, alu_b, alu_op, writeback/memory/branch

---
 rtl/decode_stage_pkg.sv | 62 ++++++
 rtl/decode_stage_if.sv | 43 ++++
 rtl/decode_stage_imm_gen.sv | 15 +
 rtl/decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_decode_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants (ALU ops, opcodes, funct3/funct7) and the decode bundle type.
// DECODE_ILLEGAL_TRAP_EN adds an illegal flag to the bundle.
package decode_stage_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_EQ  = 4'd8;
    localparam logic [3:0] ALU_NE  = 4'd9;
    localparam logic [3:0] ALU_LT  = 4'd10;
    localparam logic [3:0] ALU_GE  = 4'd11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] store_data;
        logic        is_branch;
        logic        is_jump;
        logic [31:0] target;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } dec_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side handshake plus the registered decode bundle toward execute.
// master = decode stage, slave = fetch/execute side. DECODE_ILLEGAL_TRAP_EN adds illegal.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] store_data;
    logic        is_branch;
    logic        is_jump;
    logic [31:0] target;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    modport master (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, alu_a, alu_b, alu_op, rd, rd_we,
               mem_rd, mem_wr, store_data, is_branch, is_jump, target
`ifdef DECODE_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, alu_a, alu_b, alu_op, rd, rd_we,
               mem_rd, mem_wr, store_data, is_branch, is_jump, target
`ifdef DECODE_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction, all sign-extended to 32 bits.
module imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: regfile read, immediate build, one registered bundle to execute.
// DECODE_ILLEGAL_TRAP_EN exports an illegal flag for unsupported encodings.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    decode_stage_if.master     bus,
    output logic [4:0]         rs1_addr,
    output logic [4:0]         rs2_addr,
    input  logic [31:0]        rs1_data,
    input  logic [31:0]        rs2_data,
    input  logic               hazard_stall,
    input  logic               flush
);
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd_f;
    logic        legal, wb, accept;
    dec_bundle_t d, bundle_q;
    logic        out_valid_q;

    imm_gen u_imm_gen (
        .instr (bus.in_instr),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    assign opc      = bus.in_instr[6:0];
    assign rd_f     = bus.in_instr[11:7];
    assign f3       = bus.in_instr[14:12];
    assign f7       = bus.in_instr[31:25];
    assign rs1_addr = bus.in_instr[19:15];
    assign rs2_addr = bus.in_instr[24:20];

    // x0 reads as zero whatever the regfile returns
    assign rs1_v = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
    assign rs2_v = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;

    assign bus.in_ready = !hazard_stall && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready && !flush;

    always_comb begin
        d        = '0;
        legal    = 1'b0;
        wb       = 1'b0;
        d.pc     = bus.in_pc;
        d.rd     = rd_f;
        d.alu_op = ALU_ADD;
        case (opc)
            OPC_LUI: begin
                legal   = 1'b1;
                wb      = 1'b1;
                d.alu_b = imm_u;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                wb      = 1'b1;
                d.alu_a = bus.in_pc;
                d.alu_b = imm_u;
            end
            OPC_OPIMM: begin
                wb      = 1'b1;
                d.alu_a = rs1_v;
                d.alu_b = imm_i;
                case (f3)
                    F3_ADD: begin legal = 1'b1; d.alu_op = ALU_ADD; end
                    F3_AND: begin legal = 1'b1; d.alu_op = ALU_AND; end
                    F3_OR:  begin legal = 1'b1; d.alu_op = ALU_OR;  end
                    F3_XOR: begin legal = 1'b1; d.alu_op = ALU_XOR; end
                    F3_SLL: begin legal = (f7 == F7_BASE); d.alu_op = ALU_SLL; end
                    F3_SR: begin
                        legal    = (f7 == F7_BASE) || (f7 == F7_ALT);
                        d.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                wb      = 1'b1;
                d.alu_a = rs1_v;
                d.alu_b = rs2_v;
                case (f3)
                    F3_ADD: begin
                        legal    = (f7 == F7_BASE) || (f7 == F7_ALT);
                        d.alu_op = f7[5] ? ALU_SUB : ALU_ADD;
                    end
                    F3_SR: begin
                        legal    = (f7 == F7_BASE) || (f7 == F7_ALT);
                        d.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                    end
                    F3_SLL: begin legal = (f7 == F7_BASE); d.alu_op = ALU_SLL; end
                    F3_XOR: begin legal = (f7 == F7_BASE); d.alu_op = ALU_XOR; end
                    F3_OR:  begin legal = (f7 == F7_BASE); d.alu_op = ALU_OR;  end
                    F3_AND: begin legal = (f7 == F7_BASE); d.alu_op = ALU_AND; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal    = (f3 == F3_W);
                wb       = 1'b1;
                d.alu_a  = rs1_v;
                d.alu_b  = imm_i;
                d.mem_rd = 1'b1;
            end
            OPC_STORE: begin
                legal        = (f3 == F3_W);
                d.alu_a      = rs1_v;
                d.alu_b      = imm_s;
                d.mem_wr     = 1'b1;
                d.store_data = rs2_v;
            end
            OPC_BRANCH: begin
                d.alu_a     = rs1_v;
                d.alu_b     = rs2_v;
                d.is_branch = 1'b1;
                d.target    = bus.in_pc + imm_b;
                case (f3)
                    F3_BEQ: begin legal = 1'b1; d.alu_op = ALU_EQ; end
                    F3_BNE: begin legal = 1'b1; d.alu_op = ALU_NE; end
                    F3_BLT: begin legal = 1'b1; d.alu_op = ALU_LT; end
                    F3_BGE: begin legal = 1'b1; d.alu_op = ALU_GE; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_JAL: begin
                legal     = 1'b1;
                wb        = 1'b1;
                d.alu_a   = bus.in_pc;
                d.alu_b   = 32'd4;
                d.is_jump = 1'b1;
                d.target  = bus.in_pc + imm_j;
            end
            OPC_JALR: begin
                legal     = (f3 == F3_JALR);
                wb        = 1'b1;
                d.alu_a   = bus.in_pc;
                d.alu_b   = 32'd4;
                d.is_jump = 1'b1;
                d.target  = (rs1_v + imm_i) & ~32'd1;
            end
            default: legal = 1'b0;
        endcase

        // Unsupported encodings travel as a side-effect-free bubble
        if (!legal) begin
            d       = '0;
            d.pc    = bus.in_pc;
            d.rd    = rd_f;
        end
        d.rd_we = legal && wb && (rd_f != 5'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        d.illegal = !legal;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            bundle_q.pc <= RESET_PC;
        end else begin
            // flush beats both a new accept and holding the current bundle
            if (flush)
                out_valid_q <= 1'b0;
            else if (accept)
                out_valid_q <= 1'b1;
            else if (bus.out_ready)
                out_valid_q <= 1'b0;
            if (accept)
                bundle_q <= d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = bundle_q.pc;
    assign bus.alu_a      = bundle_q.alu_a;
    assign bus.alu_b      = bundle_q.alu_b;
    assign bus.alu_op     = bundle_q.alu_op;
    assign bus.rd         = bundle_q.rd;
    assign bus.rd_we      = bundle_q.rd_we;
    assign bus.mem_rd     = bundle_q.mem_rd;
    assign bus.mem_wr     = bundle_q.mem_wr;
    assign bus.store_data = bundle_q.store_data;
    assign bus.is_branch  = bundle_q.is_branch;
    assign bus.is_jump    = bundle_q.is_jump;
    assign bus.target     = bundle_q.target;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bus.illegal    = bundle_q.illegal;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage plus handshake/flush/reset sequences.
// Checks illegal only when DECODE_ILLEGAL_TRAP_EN is defined.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        hazard_stall, flush;
    int          tests = 0;
    int          fails = 0;

    decode_stage_if bus();

    decode_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .hazard_stall (hazard_stall),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, pc, rs1d, rs2d;
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we, mrd, mwr;
        logic [31:0] sd;
        logic        br, jp;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        rs1_data     = r1;
        rs2_data     = r2;
    endtask

    initial begin
        //           instr         pc       rs1d          rs2d          alu_a         alu_b         op  rd  we mrd mwr store_data    br jp target        ill
        vt[0]  = '{32'hFFF10093, 32'h0,   32'd5,        32'd7,        32'd5,        32'hFFFFFFFF, 0,  1,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0};
        vt[1]  = '{32'h402081B3, 32'h0,   32'd10,       32'd3,        32'd10,       32'd3,        1,  3,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0};
        vt[2]  = '{32'h00209463, 32'h100, 32'd1,        32'd2,        32'd1,        32'd2,        9,  8,  0, 0, 0, 32'h0,        1, 0, 32'h108,      0};
        vt[3]  = '{32'h0020A1B3, 32'h0,   32'd11,       32'd22,       32'h0,        32'h0,        0,  3,  0, 0, 0, 32'h0,        0, 0, 32'h0,        1};
        vt[4]  = '{32'h00108033, 32'h0,   32'd4,        32'd9,        32'd4,        32'd9,        0,  0,  0, 0, 0, 32'h0,        0, 0, 32'h0,        0};
        vt[5]  = '{32'h123452B7, 32'h0,   32'hAA,       32'hBB,       32'h0,        32'h12345000, 0,  5,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0};
        vt[6]  = '{32'hFFFFF317, 32'h200, 32'h0,        32'h0,        32'h200,      32'hFFFFF000, 0,  6,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0};
        vt[7]  = '{32'hFFC42383, 32'h0,   32'h1000,     32'd5,        32'h1000,     32'hFFFFFFFC, 0,  7,  1, 1, 0, 32'h0,        0, 0, 32'h0,        0};
        vt[8]  = '{32'h00952623, 32'h0,   32'h2000,     32'hDEADBEEF, 32'h2000,     32'hC,        0,  12, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
        vt[9]  = '{32'hFF1FF0EF, 32'h300, 32'd9,        32'd9,        32'h300,      32'd4,        0,  1,  1, 0, 0, 32'h0,        0, 1, 32'h2F0,      0};
        vt[10] = '{32'h00508067, 32'h400, 32'h1000,     32'd9,        32'h400,      32'd4,        0,  0,  0, 0, 0, 32'h0,        0, 1, 32'h1004,     0};
        vt[11] = '{32'h4031D113, 32'h0,   32'h80000000, 32'h0,        32'h80000000, 32'h403,      7,  2,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0};
        vt[12] = '{32'hFE505EE3, 32'h500, 32'h777,      32'd6,        32'h0,        32'd6,        11, 29, 0, 0, 0, 32'h0,        1, 0, 32'h4FC,      0};
        vt[13] = '{32'h00000001, 32'h0,   32'd5,        32'd5,        32'h0,        32'h0,        0,  0,  0, 0, 0, 32'h0,        0, 0, 32'h0,        1};
        vt[14] = '{32'h7FF24213, 32'h0,   32'h0F0F0F0F, 32'h0,        32'h0F0F0F0F, 32'h7FF,      4,  4,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0};

        rst = 1'b1; hazard_stall = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0; bus.out_ready = 1'b1;
        rs1_data = 32'h0; rs2_data = 32'h0;

        repeat (2) @(negedge clk);
        chk("reset.out_valid", bus.out_valid, 1'b0);
        chk("reset.out_pc", bus.out_pc, 32'h0);
        chk("reset.alu_op", bus.alu_op, 4'd0);
        chk("reset.rd_we", bus.rd_we, 1'b0);
        chk("reset.in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].instr, vt[i].pc, vt[i].rs1d, vt[i].rs2d);
            if (i == 0) begin
                #1;
                chk("addi.rs1_addr", rs1_addr, 5'd2);
                chk("addi.rs2_addr", rs2_addr, 5'd31);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d.out_valid", i), bus.out_valid, 1'b1);
            chk($sformatf("v%0d.out_pc", i), bus.out_pc, vt[i].pc);
            chk($sformatf("v%0d.alu_a", i), bus.alu_a, vt[i].a);
            chk($sformatf("v%0d.alu_b", i), bus.alu_b, vt[i].b);
            chk($sformatf("v%0d.alu_op", i), bus.alu_op, vt[i].op);
            chk($sformatf("v%0d.rd", i), bus.rd, vt[i].rd);
            chk($sformatf("v%0d.rd_we", i), bus.rd_we, vt[i].we);
            chk($sformatf("v%0d.mem_rd", i), bus.mem_rd, vt[i].mrd);
            chk($sformatf("v%0d.mem_wr", i), bus.mem_wr, vt[i].mwr);
            chk($sformatf("v%0d.store_data", i), bus.store_data, vt[i].sd);
            chk($sformatf("v%0d.is_branch", i), bus.is_branch, vt[i].br);
            chk($sformatf("v%0d.is_jump", i), bus.is_jump, vt[i].jp);
            chk($sformatf("v%0d.target", i), bus.target, vt[i].tgt);
`ifdef DECODE_ILLEGAL_TRAP_EN
            chk($sformatf("v%0d.illegal", i), bus.illegal, vt[i].ill);
`endif
        end

        // back-pressure: ADDI held for 3 cycles while LUI waits
        @(negedge clk);
        drive(32'hFFF10093, 32'h0, 32'd5, 32'd7);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(32'h123452B7, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d.in_ready", k), bus.in_ready, 1'b0);
            chk($sformatf("bp%0d.out_valid", k), bus.out_valid, 1'b1);
            chk($sformatf("bp%0d.alu_a", k), bus.alu_a, 32'd5);
            chk($sformatf("bp%0d.alu_b", k), bus.alu_b, 32'hFFFFFFFF);
            chk($sformatf("bp%0d.rd", k), bus.rd, 5'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1 chk("bp.in_ready_release", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        chk("bp.next_valid", bus.out_valid, 1'b1);
        chk("bp.next_rd", bus.rd, 5'd5);
        chk("bp.next_alu_b", bus.alu_b, 32'h12345000);

        // flush with a valid bundle and an incoming SUB
        @(negedge clk);
        flush = 1'b1;
        drive(32'h402081B3, 32'h0, 32'd10, 32'd3);
        @(posedge clk); #1;
        chk("flush.out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush.no_ghost", bus.out_valid, 1'b0);

        // flush overrides a held bundle
        @(negedge clk);
        drive(32'hFFF10093, 32'h0, 32'd5, 32'd7);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_hold.out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        flush = 1'b0; bus.out_ready = 1'b1;

        // hazard stall blocks acceptance
        hazard_stall = 1'b1;
        drive(32'hFFF10093, 32'h40, 32'd5, 32'd7);
        #1 chk("stall.in_ready", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        chk("stall.out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        hazard_stall = 1'b0;
        @(posedge clk); #1;
        chk("stall.release_valid", bus.out_valid, 1'b1);
        chk("stall.release_pc", bus.out_pc, 32'h40);

        // asynchronous reset mid-stream
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst.out_valid", bus.out_valid, 1'b0);
        chk("midrst.out_pc", bus.out_pc, 32'h0);
        chk("midrst.rd", bus.rd, 5'd0);
        @(negedge clk);
        rst = 1'b0; bus.out_ready = 1'b1;
        drive(32'h402081B3, 32'h8, 32'd10, 32'd3);
        @(posedge clk); #1;
        chk("postrst.out_valid", bus.out_valid, 1'b1);
        chk("postrst.alu_op", bus.alu_op, 4'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("postrst.drain", bus.out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
